// File: rtl/cursor_control.sv
// VT52 cursor state: position registers, two-way round-robin update arbiter,
// and vblank-driven blink phase for the character renderer.
module cursor_control #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 24,
    parameter int unsigned COL_BITS   = 7,
    parameter int unsigned ROW_BITS   = 5,
    parameter int unsigned BLINK_BITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vblank,
    input  logic                cmd_valid,
    input  logic                cmd_rel,
    input  logic [ROW_BITS-1:0] cmd_row,
    input  logic [COL_BITS-1:0] cmd_col,
    output logic                cmd_ready,
    input  logic                scroll_valid,
    input  logic                scroll_up,
    output logic                scroll_ready,
    input  logic                cursor_enable,
    input  logic                blink_enable,
    output logic [ROW_BITS-1:0] cursor_row,
    output logic [COL_BITS-1:0] cursor_col,
    output logic                cursor_visible,
    output logic                moved
);

    // Two guard bits keep the largest position plus the largest delta from wrapping.
    localparam int unsigned RW = ROW_BITS + 2;
    localparam int unsigned CW = COL_BITS + 2;
    localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(COLS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic                  last_scroll;
    logic                  grant_cmd;
    logic                  grant_scr;

    logic                  req_scroll;
    logic                  req_rel;
    logic                  req_up;
    logic [ROW_BITS-1:0]   req_row;
    logic [COL_BITS-1:0]   req_col;

    logic [RW-1:0]         row_dlt;
    logic [CW-1:0]         col_dlt;
    logic [RW-1:0]         row_sum;
    logic [CW-1:0]         col_sum;
    logic [ROW_BITS-1:0]   row_nx;
    logic [COL_BITS-1:0]   col_nx;

    logic                  vblank_q;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  blink_on;

    // Round-robin grant: on a tie the requester not served last wins.
    always_comb begin
        grant_cmd = 1'b0;
        grant_scr = 1'b0;
        if (state == IDLE) begin
            grant_cmd = cmd_valid && cmd_ready && (!(scroll_valid && scroll_ready) || last_scroll);
            grant_scr = scroll_valid && scroll_ready && !grant_cmd;
        end
    end

    // Next-state: a grant moves to APPLY, APPLY always lasts one cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_cmd || grant_scr) state_nx = APPLY;
            APPLY:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // New position from the latched request, saturated to the screen.
    always_comb begin
        row_dlt = '0;
        col_dlt = {{2{req_col[COL_BITS-1]}}, req_col};
        row_nx  = cursor_row;
        col_nx  = cursor_col;
        if (req_scroll) begin
            row_dlt = req_up ? '1 : RW'(1);
        end else begin
            row_dlt = {{2{req_row[ROW_BITS-1]}}, req_row};
        end
        row_sum = {2'b00, cursor_row} + row_dlt;
        col_sum = {2'b00, cursor_col} + col_dlt;

        if (req_scroll || req_rel) begin
            if (row_sum[RW-1])                row_nx = '0;
            else if (row_sum > RW'(ROWS - 1)) row_nx = ROW_MAX;
            else                              row_nx = row_sum[ROW_BITS-1:0];
        end else begin
            row_nx = (req_row > ROW_MAX) ? ROW_MAX : req_row;
        end

        if (req_scroll) begin
            col_nx = cursor_col;
        end else if (req_rel) begin
            if (col_sum[CW-1])                col_nx = '0;
            else if (col_sum > CW'(COLS - 1)) col_nx = COL_MAX;
            else                              col_nx = col_sum[COL_BITS-1:0];
        end else begin
            col_nx = (req_col > COL_MAX) ? COL_MAX : req_col;
        end
    end

    // State, handshake, request latch and position registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_scroll  <= 1'b1;
            cmd_ready    <= 1'b0;
            scroll_ready <= 1'b0;
            moved        <= 1'b0;
            cursor_row   <= '0;
            cursor_col   <= '0;
            req_scroll   <= 1'b0;
            req_rel      <= 1'b0;
            req_up       <= 1'b0;
            req_row      <= '0;
            req_col      <= '0;
        end else begin
            state        <= state_nx;
            cmd_ready    <= (state_nx == IDLE);
            scroll_ready <= (state_nx == IDLE);
            moved        <= (state == APPLY);
            if (grant_cmd || grant_scr) begin
                req_scroll  <= grant_scr;
                req_rel     <= cmd_rel;
                req_up      <= scroll_up;
                req_row     <= cmd_row;
                req_col     <= cmd_col;
                last_scroll <= grant_scr;
            end
            if (state == APPLY) begin
                cursor_row <= row_nx;
                cursor_col <= col_nx;
            end
        end
    end

    // Blink counter: counts vblank rising edges, held at zero around a move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vblank_q  <= 1'b0;
            blink_cnt <= '0;
        end else begin
            vblank_q <= vblank;
            if (state == APPLY || moved) begin
                blink_cnt <= '0;
            end else if (vblank && !vblank_q) begin
                blink_cnt <= blink_cnt + BLINK_BITS'(1);
            end
        end
    end

    assign blink_on       = ~blink_cnt[BLINK_BITS-1];
    assign cursor_visible = cursor_enable && (!blink_enable || blink_on);

endmodule
